// File: rtl/tdc_pg_pkg.sv
// Shared types for the TDC pulse-pattern generator: run-state encoding and mode values.
// Constants only: no logic, no latency, no backpressure.
package tdc_pg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/tdc_pulse_pattern_gen_if.sv
// Control and pattern-output bundle of the pulse-pattern generator.
// Wires only: no latency; no backpressure, every output is free-running.
interface tdc_pulse_pattern_gen_if #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int WW  = 8,
    parameter int FW  = 16
);
    logic                start;
    logic                stop;
    logic                mode;
    logic [FW-1:0]       burst_len;
    logic [CW-1:0]       period;
    logic [NCH*CW-1:0]   delay;
    logic [NCH*WW-1:0]   width;
    logic                ref_pulse;
    logic [NCH-1:0]      pulse_out;
    logic                busy;
    logic                done;

    modport master (
        output start, stop, mode, burst_len, period, delay, width,
        input  ref_pulse, pulse_out, busy, done
    );

    modport slave (
        input  start, stop, mode, burst_len, period, delay, width,
        output ref_pulse, pulse_out, busy, done
    );
endinterface

// File: rtl/tdc_pg_channel.sv
// One channel's window comparator: high while delay_i <= count < delay_i + width_i.
// Combinational, latency 0; no backpressure.
module tdc_pg_channel #(
    parameter int CW = 16,
    parameter int WW = 8
) (
    input  logic [CW-1:0] count,
    input  logic [CW-1:0] delay_i,
    input  logic [WW-1:0] width_i,
    output logic          win
);
    logic [CW:0] cnt_x;
    logic [CW:0] lo;
    logic [CW:0] hi;

    // One extra bit so delay + width never wraps back into the frame.
    always_comb begin
        cnt_x = {1'b0, count};
        lo    = {1'b0, delay_i};
        hi    = lo + (CW+1)'(width_i);
        win   = (cnt_x >= lo) && (cnt_x < hi);
    end
endmodule

// File: rtl/tdc_pulse_pattern_gen.sv
// Multi-channel frame-based pulse-pattern generator: ref pulse per frame plus per-channel windows.
// Outputs registered, latency 1 from frame count; no backpressure, runs until burst end or stop.
module tdc_pulse_pattern_gen
    import tdc_pg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int WW  = 8,
    parameter int FW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    tdc_pulse_pattern_gen_if.slave   bus
);
    typedef struct packed {
        logic                mode;
        logic [FW-1:0]       burst_len;
        logic [CW-1:0]       period;
        logic [NCH*CW-1:0]   delay;
        logic [NCH*WW-1:0]   width;
    } cfg_t;

    cfg_t            cfg_in;
    cfg_t            cfg_s;
    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [FW-1:0]   frames;
    logic            stop_flag;
    logic [NCH-1:0]  win;

    logic            start_ok;
    logic            wrap;
    logic            last_burst;
    logic            stop_pend;

    logic            ref_d;
    logic [NCH-1:0]  pulse_d;
    logic            busy_d;
    logic            done_d;
    logic            ref_q;
    logic [NCH-1:0]  pulse_q;
    logic            busy_q;
    logic            done_q;

    assign cfg_in = {bus.mode, bus.burst_len, bus.period, bus.delay, bus.width};

    // A zero-length burst would never end cleanly, so such a start is dropped.
    assign start_ok   = bus.start && ((bus.mode == MODE_CONT) || (bus.burst_len != '0));
    assign wrap       = (count == cfg_s.period);
    assign last_burst = (cfg_s.mode == MODE_BURST) && ((frames + FW'(1)) == cfg_s.burst_len);
    assign stop_pend  = stop_flag || bus.stop;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tdc_pg_channel #(
            .CW (CW),
            .WW (WW)
        ) u_ch (
            .count   (count),
            .delay_i (cfg_s.delay[i*CW +: CW]),
            .width_i (cfg_s.width[i*WW +: WW]),
            .win     (win[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (wrap && (last_burst || stop_pend)) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ref_d   = 1'b0;
        pulse_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                busy_d = start_ok;
            end
            RUN: begin
                ref_d   = (count == '0);
                pulse_d = win;
                busy_d  = 1'b1;
                done_d  = (state_nxt == FLUSH);
            end
            default: ;
        endcase
    end

    // Shadow config reloads only at frame wrap, so input changes land on frame boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            frames    <= '0;
            stop_flag <= 1'b0;
            cfg_s     <= '0;
            ref_q     <= 1'b0;
            pulse_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ref_q   <= ref_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            case (state)
                IDLE: begin
                    stop_flag <= 1'b0;
                    if (start_ok) begin
                        count  <= '0;
                        frames <= '0;
                        cfg_s  <= cfg_in;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        count  <= '0;
                        frames <= frames + FW'(1);
                        cfg_s  <= cfg_in;
                    end else begin
                        count <= count + CW'(1);
                    end
                    stop_flag <= (state_nxt == RUN) ? stop_pend : 1'b0;
                end
                default: begin
                    stop_flag <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ref_pulse = ref_q;
    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_tdc_pulse_pattern_gen.sv
// Bench for tdc_pulse_pattern_gen: directed plan cases plus random runs checked against a
// per-frame trace built from the frame/window rules.
module tb_tdc_pulse_pattern_gen;
    import tdc_pg_pkg::*;

    localparam int NCH  = 4;
    localparam int CW   = 16;
    localparam int WW   = 8;
    localparam int FW   = 16;
    localparam int MAXF = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tdc_pulse_pattern_gen_if #(.NCH(NCH), .CW(CW), .WW(WW), .FW(FW)) bus ();

    tdc_pulse_pattern_gen #(.NCH(NCH), .CW(CW), .WW(WW), .FW(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Frame plan: frame f of a run uses per_a/dly_a/wid_a[f].
    int   per_a [MAXF];
    int   dly_a [MAXF][NCH];
    int   wid_a [MAXF][NCH];
    int   nfr;
    logic mode_v;
    bit   garbage;
    int   change_k;
    int   stop_k;
    int   abort_t;

    logic [6:0] obs_w;
    assign obs_w = {bus.ref_pulse, bus.pulse_out, bus.busy, bus.done};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed={ref,pulse,busy,done}=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic setf(input int f, input int p,
                        input int d0, input int d1, input int d2, input int d3,
                        input int w0, input int w1, input int w2, input int w3);
        per_a[f] = p;
        dly_a[f][0] = d0; dly_a[f][1] = d1; dly_a[f][2] = d2; dly_a[f][3] = d3;
        wid_a[f][0] = w0; wid_a[f][1] = w1; wid_a[f][2] = w2; wid_a[f][3] = w3;
    endtask

    task automatic drive_cfg(input int f);
        bus.period = CW'(per_a[f]);
        for (int i = 0; i < NCH; i++) begin
            bus.delay[i*CW +: CW] = CW'(dly_a[f][i]);
            bus.width[i*WW +: WW] = WW'(wid_a[f][i]);
        end
    endtask

    task automatic drive_garbage();
        bus.period = CW'($urandom_range(0, 20));
        for (int i = 0; i < NCH; i++) begin
            bus.delay[i*CW +: CW] = CW'($urandom_range(0, 20));
            bus.width[i*WW +: WW] = WW'($urandom_range(0, 12));
        end
    endtask

    task automatic do_run(input string tag);
        logic [6:0] exp_q[$];
        int         fr_q[$];
        int         k_q[$];
        logic [6:0] e;
        int         len;
        int         f;
        int         k;

        for (int fi = 0; fi < nfr; fi++) begin
            for (int ki = 0; ki <= per_a[fi]; ki++) begin
                e    = '0;
                e[6] = (ki == 0);
                for (int i = 0; i < NCH; i++)
                    e[2+i] = (ki >= dly_a[fi][i]) && (ki < dly_a[fi][i] + wid_a[fi][i]);
                e[1] = 1'b1;
                e[0] = (fi == nfr - 1) && (ki == per_a[fi]);
                exp_q.push_back(e);
                fr_q.push_back(fi);
                k_q.push_back(ki);
            end
        end
        exp_q.push_back(7'b0);
        fr_q.push_back(-1);
        k_q.push_back(-1);
        len = exp_q.size();

        drive_cfg(0);
        bus.mode      = mode_v;
        bus.burst_len = (mode_v == MODE_BURST) ? FW'(nfr) : FW'($urandom_range(0, 3));
        bus.stop      = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        for (int t = 1; t <= len; t++) begin
            f = fr_q[t-1];
            k = k_q[t-1];
            if (f >= 0) begin
                if (f + 1 < nfr && k == per_a[f]) drive_cfg(f + 1);
                else if (garbage)                  drive_garbage();
                else if (f + 1 < nfr && k >= change_k) drive_cfg(f + 1);
                else                               drive_cfg(f);
                bus.stop  = (mode_v == MODE_CONT) && (f == nfr - 1) && (k == stop_k);
                bus.start = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bus.stop  = 1'($urandom_range(0, 1));
                bus.start = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (t == abort_t) reset = 1'b1;
            @(posedge clk); #1;
            if (t == abort_t) begin
                reset     = 1'b0;
                bus.start = 1'b0;
                bus.stop  = 1'b0;
                check($sformatf("%s reset_cut t=%0d", tag, t), obs_w, 7'b0);
                for (int j = 0; j < 12; j++) begin
                    @(posedge clk); #1;
                    check($sformatf("%s after_reset j=%0d", tag, j), obs_w, 7'b0);
                end
                return;
            end
            check($sformatf("%s t=%0d frame=%0d k=%0d", tag, t, f, k), obs_w, exp_q[t-1]);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s idle_after", tag), obs_w, 7'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mode      = MODE_CONT;
        bus.burst_len = '0;
        bus.period    = '0;
        bus.delay     = '0;
        bus.width     = '0;
        garbage  = 1'b0;
        change_k = 1000;
        stop_k   = -1;
        abort_t  = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs_w, 7'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", obs_w, 7'b0);

        // Plan: single-frame burst with truncated and end-of-frame windows.
        mode_v = MODE_BURST; nfr = 1;
        setf(0, 9, 0, 2, 5, 9, 1, 3, 10, 1);
        do_run("burst1");

        // Three-frame burst; unrelated inputs scrambled between frame boundaries.
        nfr = 3; garbage = 1'b1;
        for (int fi = 1; fi < 3; fi++) setf(fi, 9, 0, 2, 5, 9, 1, 3, 10, 1);
        do_run("burst3");

        // Continuous, stop during frame 5 at count 2.
        mode_v = MODE_CONT; nfr = 6; stop_k = 2;
        for (int fi = 0; fi < 6; fi++) setf(fi, 4, 0, 1, 3, 4, 2, 1, 5, 1);
        do_run("cont_stop");

        // delay[0] moves 0 -> 3 in the middle of frame 0.
        mode_v = MODE_BURST; nfr = 2; garbage = 1'b0; change_k = 4; stop_k = -1;
        setf(0, 9, 0, 2, 5, 9, 1, 3, 10, 1);
        setf(1, 9, 3, 2, 5, 9, 1, 3, 10, 1);
        do_run("delay_change");
        change_k = 1000;

        // One-cycle frames.
        mode_v = MODE_CONT; nfr = 5; stop_k = 0; garbage = 1'b1;
        for (int fi = 0; fi < 5; fi++) setf(fi, 0, 0, 0, 1, 0, 1, 0, 1, 5);
        do_run("period0");

        // Zero widths and a delay beyond the frame.
        mode_v = MODE_BURST; nfr = 2; stop_k = -1;
        setf(0, 6, 0, 1, 3, 7, 0, 2, 0, 7);
        setf(1, 6, 2, 1, 3, 9, 0, 6, 0, 3);
        do_run("width0");

        // Burst of zero frames: start must be dropped.
        bus.mode      = MODE_BURST;
        bus.burst_len = '0;
        bus.start     = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            check($sformatf("burst_len0 j=%0d", j), obs_w, 7'b0);
        end
        bus.start = 1'b0;

        // Reset at count 3 of frame 1 of a five-frame burst, then a clean restart.
        mode_v = MODE_BURST; nfr = 5; garbage = 1'b0;
        for (int fi = 0; fi < 5; fi++) setf(fi, 6, 0, 2, 4, 6, 3, 2, 5, 1);
        abort_t = (6 + 1) + 3 + 1;
        do_run("reset_mid");
        abort_t = 0;
        nfr = 2;
        do_run("restart");

        // Random runs.
        garbage = 1'b1;
        for (int r = 0; r < 10; r++) begin
            mode_v = 1'($urandom_range(0, 1));
            nfr    = $urandom_range(1, 4);
            for (int fi = 0; fi < nfr; fi++) begin
                per_a[fi] = $urandom_range(0, 12);
                for (int i = 0; i < NCH; i++) begin
                    dly_a[fi][i] = $urandom_range(0, 14);
                    wid_a[fi][i] = $urandom_range(0, 6);
                end
            end
            stop_k = (mode_v == MODE_CONT) ? $urandom_range(0, per_a[nfr-1]) : -1;
            do_run($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_pulse_pattern_gen.md
# tdc_pulse_pattern_gen

Multi-channel programmable pulse-pattern generator for TDC characterisation. It repeats a frame of `period+1` clock cycles. It emits a one-cycle reference pulse at the start of each frame, and each channel drives a window pulse with its own delay and width. Runs continuously or for a fixed burst of frames, and replaces the fixed two-pulse generator as stimulus source for the TDC channels.

## Interface
Parameters:
- `NCH`, 4, number of delayed output channels (1..16)
- `CW`, 16, frame counter / delay / period width
- `WW`, 8, pulse-width field width per channel
- `FW`, 16, burst frame-count width

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a run; sampled only in IDLE
- `stop` in 1: request end of run after the current frame; sampled only in RUN
- `mode` in 1: 0 = continuous, 1 = burst
- `burst_len` in FW: number of frames in burst mode
- `period` in CW: frame length minus one
- `delay` in NCH*CW: per-channel start offset; channel i uses bits [i*CW +: CW]
- `width` in NCH*WW: per-channel pulse width in cycles; channel i uses bits [i*WW +: WW]
- `ref_pulse` out 1: high one cycle at each frame start
- `pulse_out` out NCH: channel window pulses
- `busy` out 1: high in RUN and FLUSH
- `done` out 1: one-cycle pulse that coincides with the last frame's final output cycle

## Operation
- States are IDLE, RUN and FLUSH.
- **IDLE → RUN:**
  - Occurs on `start`. In burst mode it additionally requires `burst_len != 0`; if `burst_len == 0` in burst mode, `start` is ignored and no `done` is produced.
  - On entry: `count` <= 0, `frames` <= 0.
  - `mode`, `burst_len`, `period`, `delay` and `width` are copied into shadow registers.
- **In RUN, per edge:**
  - Outputs <= f(`count`).
  - `count` increments. When `count == period_s` it wraps to 0, `frames` increments, and the shadow registers reload from the inputs. Input changes therefore take effect only at frame boundaries.
- **Output function f(`count`):**
  - `ref_pulse` = (`count == 0`).
  - `pulse_out[i]` = (`count >= delay_i`) && (`count < delay_i + width_i`). The sum is evaluated at CW+1 bits, so there is no wrap.
  - A window extending past `period_s` is truncated at the frame end.
  - `width_i == 0`, or `delay_i > period_s`, means the channel never pulses.
- **RUN → FLUSH:** on the wrap edge when either condition holds:
  - burst mode with `frames+1 == burst_len_s`;
  - `stop` is pending. `stop` is latched as a sticky flag in any RUN cycle and cleared on leaving RUN.
- In continuous mode the run ends only via `stop`.
- `done` <= 1 on the same edge as entering FLUSH.
- **FLUSH → IDLE:** unconditional on the next edge; all outputs <= 0 and `done` <= 0.
- `period == 0`: each frame is 1 cycle, so `ref_pulse` stays high continuously while running.
- `start` in RUN/FLUSH and `stop` in IDLE/FLUSH are ignored.

## Timing
- Reset value of every output is 0: `ref_pulse`, `pulse_out`, `busy`, `done`. State returns to IDLE and `count`/`frames`/stop flag clear.
- Reset asserted mid-run: all outputs are 0 in the cycle after the edge, and no `done` is issued.
- Outputs are registered with latency 1: the value for `count = k` appears in the cycle after `count == k`.
- For `start` sampled at edge E0: `ref_pulse` is high after E1, E1+(P+1), and so on.
- Burst of B frames of P+1 cycles: `done` is high after edge E0 + B·(P+1), and `busy` falls after the following edge.
- `busy` is high from the cycle after E0 through the `done` cycle.
- Channel rising edges relative to `ref_pulse` are exactly `delay_i` cycles, with no jitter.

## Structure
- Package `tdc_pg_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH);
  - mode constants `MODE_CONT = 0` and `MODE_BURST = 1`.
- Sub-module `tdc_pg_channel`, instantiated NCH times via generate:
  - inputs: `count`, `delay_i`, `width_i`;
  - contains the CW+1-bit window comparator;
  - produces a combinational window bit, registered in the top.
- Top holds the FSM, frame counter, burst counter, stop flag, shadow registers and output registers.

## Test plan
- NCH=4, period=9, delay={0,2,5,9}, width={1,3,10,1}, burst B=1:
  - ch0 high at count 0 only; ch1 high at counts 2–4; ch2 high at counts 5–9 (truncated); ch3 high at count 9 only;
  - `done` coincides with ch2/ch3 high at count 9.
- Burst B=3, period=9, start at E0: `ref_pulse` after E1, E11 and E21; `done` after E30; `busy` low after E31.
- Continuous mode with period=4, `stop` pulsed at count 2 of frame 5: frame 5 completes, `done` is emitted with its count-4 output, and no frame 6 starts.
- Change `delay[0]` from 0 to 3 mid-frame: the current frame keeps ch0 at count 0; the next frame moves ch0 to count 3.
- Edge cases:
  - `period=0`: `ref_pulse` stays high continuously;
  - `width=0`: channel stays silent;
  - burst mode with `burst_len=0`: `start` ignored and `busy` stays 0;
  - `start` asserted during RUN is ignored.
- `reset` asserted at count 3 of frame 1 of a B=5 burst: all outputs are 0 the next cycle and no `done` appears. A subsequent `start` restarts cleanly from count 0.
